// File: rtl/regfile_mp.sv
// Two-read / two-write register file with a pending-write scoreboard and a zero-sweep sequencer.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_clear,
    output logic                     o_ready,
    input  logic [$clog2(NREG)-1:0]  i_rd_addr0,
    input  logic [$clog2(NREG)-1:0]  i_rd_addr1,
    output logic [XLEN-1:0]          o_rd_data0,
    output logic [XLEN-1:0]          o_rd_data1,
    output logic                     o_rd_busy0,
    output logic                     o_rd_busy1,
    input  logic                     i_wr_en0,
    input  logic                     i_wr_en1,
    input  logic [$clog2(NREG)-1:0]  i_wr_addr0,
    input  logic [$clog2(NREG)-1:0]  i_wr_addr1,
    input  logic [XLEN-1:0]          i_wr_data0,
    input  logic [XLEN-1:0]          i_wr_data1,
    input  logic                     i_alloc_en,
    input  logic [$clog2(NREG)-1:0]  i_alloc_addr
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;
    logic            wr_ok, sb_clr, we0, we1, alloc_ok;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_CLEAR;
            clr_idx <= AW'(1);
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            S_IDLE: begin
                if (i_clear) begin
                    state_nxt   = S_CLEAR;
                    clr_idx_nxt = AW'(1);
                end
            end
            S_CLEAR: begin
                if (clr_idx == AW'(NREG - 1))
                    state_nxt = S_IDLE;
                else
                    clr_idx_nxt = clr_idx + AW'(1);
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        o_ready = (state == S_IDLE);
        wr_ok   = o_ready & ~i_clear;
        sb_clr  = o_ready & i_clear;
    end

    // Port 0 is suppressed on a collision so only port 1's data lands.
    assign we1      = wr_ok & i_wr_en1 & (i_wr_addr1 != '0);
    assign we0      = wr_ok & i_wr_en0 & (i_wr_addr0 != '0) & ~(we1 & (i_wr_addr1 == i_wr_addr0));
    assign alloc_ok = wr_ok & i_alloc_en & (i_alloc_addr != '0);

    always_ff @(posedge i_clock) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else begin
            if (we0) mem[i_wr_addr0] <= i_wr_data0;
            if (we1) mem[i_wr_addr1] <= i_wr_data1;
        end
    end

    // Later assignment wins, so a same-cycle alloc overrides a write's clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy <= '0;
        end else if (sb_clr) begin
            busy <= '0;
        end else if (wr_ok) begin
            for (int i = 1; i < NREG; i++) begin
                if ((we0 && i_wr_addr0 == AW'(i)) || (we1 && i_wr_addr1 == AW'(i)))
                    busy[i] <= 1'b0;
                if (alloc_ok && i_alloc_addr == AW'(i))
                    busy[i] <= 1'b1;
            end
        end
    end

    assign rd_addr[0] = i_rd_addr0;
    assign rd_addr[1] = i_rd_addr1;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rd_data[k] = mem[rd_addr[k]];
            rd_busy[k] = busy[rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
            if (we1 && i_wr_addr1 == rd_addr[k]) begin
                rd_data[k] = i_wr_data1;
                rd_busy[k] = busy[rd_addr[k]] & alloc_ok & (i_alloc_addr == rd_addr[k]);
            end else if (we0 && i_wr_addr0 == rd_addr[k]) begin
                rd_data[k] = i_wr_data0;
                rd_busy[k] = busy[rd_addr[k]] & alloc_ok & (i_alloc_addr == rd_addr[k]);
            end
`endif
            if (!o_ready || rd_addr[k] == '0) begin
                rd_data[k] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

    assign o_rd_data0 = rd_data[0];
    assign o_rd_data1 = rd_data[1];
    assign o_rd_busy0 = rd_busy[0];
    assign o_rd_busy1 = rd_busy[1];

endmodule
